// File: rtl/clock_pkg.sv
// Shared types and limits for the time-of-day keeper.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SET_HH = 2'd1,
    SET_MM = 2'd2
  } mode_t;

  localparam logic [5:0] SEC_MAX  = 6'd59;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [4:0] HOUR_MAX = 5'd23;

endpackage

// File: rtl/bin_to_bcd.sv
// Combinational 6-bit binary (0..59) to two-digit packed BCD converter.
module bin_to_bcd (
  input  logic [5:0] bin,
  output logic [7:0] bcd
);

  logic [3:0] tens;
  logic [3:0] ones;

  // Range compare + subtract avoids a divider for such a small input span.
  always_comb begin
    tens = 4'd0;
    ones = bin[3:0];
    if (bin >= 6'd50) begin
      tens = 4'd5;
      ones = 4'(bin - 6'd50);
    end else if (bin >= 6'd40) begin
      tens = 4'd4;
      ones = 4'(bin - 6'd40);
    end else if (bin >= 6'd30) begin
      tens = 4'd3;
      ones = 4'(bin - 6'd30);
    end else if (bin >= 6'd20) begin
      tens = 4'd2;
      ones = 4'(bin - 6'd20);
    end else if (bin >= 6'd10) begin
      tens = 4'd1;
      ones = 4'(bin - 6'd10);
    end
  end

  assign bcd = {tens, ones};

endmodule

// File: rtl/time_keeper.sv
// Time-of-day keeper with RUN / SET_HH / SET_MM editing and blinking digit enables.
// Define CLOCK_12H_EN for a 12-hour display with pm flag; counting stays 24-hour.
module time_keeper
  import clock_pkg::*;
#(
  parameter int RST_HH = 0,
  parameter int RST_MM = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pulse_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [7:0] hh_bcd,
  output logic [7:0] mm_bcd,
  output logic [7:0] ss_bcd,
  output logic [5:0] digit_en,
  output logic [1:0] mode,
  output logic       day_tick,
  output logic       pm
);

  mode_t      mode_q, mode_d;
  logic [5:0] sec_q, sec_d;
  logic [5:0] min_q, min_d;
  logic [4:0] hour_q, hour_d;
  logic       blink_q, blink_d;
  logic       day_tick_q, day_tick_d;
  logic [5:0] hour_disp;

  always_comb begin
    mode_d     = mode_q;
    sec_d      = sec_q;
    min_d      = min_q;
    hour_d     = hour_q;
    blink_d    = blink_q;
    day_tick_d = 1'b0;
    case (mode_q)
      RUN: begin
        blink_d = 1'b1;
        if (pulse_1hz) begin
          if (sec_q == SEC_MAX) begin
            sec_d = 6'd0;
            if (min_q == MIN_MAX) begin
              min_d = 6'd0;
              if (hour_q == HOUR_MAX) begin
                hour_d     = 5'd0;
                day_tick_d = 1'b1;
              end else begin
                hour_d = hour_q + 5'd1;
              end
            end else begin
              min_d = min_q + 6'd1;
            end
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end
        if (btn_mode) mode_d = SET_HH;
      end
      SET_HH: begin
        if (pulse_1hz) blink_d = ~blink_q;
        if (btn_mode) begin
          mode_d = SET_MM;
        end else if (btn_inc) begin
          hour_d = (hour_q == HOUR_MAX) ? 5'd0 : hour_q + 5'd1;
        end
      end
      SET_MM: begin
        if (pulse_1hz) blink_d = ~blink_q;
        // Leaving the editor restarts the minute cleanly from :00.
        if (btn_mode) begin
          mode_d  = RUN;
          sec_d   = 6'd0;
          blink_d = 1'b1;
        end else if (btn_inc) begin
          min_d = (min_q == MIN_MAX) ? 6'd0 : min_q + 6'd1;
        end
      end
      default: begin
        mode_d  = RUN;
        blink_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q     <= RUN;
      sec_q      <= 6'd0;
      min_q      <= 6'(RST_MM);
      hour_q     <= 5'(RST_HH);
      blink_q    <= 1'b1;
      day_tick_q <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hour_q     <= hour_d;
      blink_q    <= blink_d;
      day_tick_q <= day_tick_d;
    end
  end

`ifdef CLOCK_12H_EN
  always_comb begin
    if (hour_q == 5'd0)       hour_disp = 6'd12;
    else if (hour_q > 5'd12)  hour_disp = {1'b0, hour_q - 5'd12};
    else                      hour_disp = {1'b0, hour_q};
  end
  assign pm = (hour_q >= 5'd12);
`else
  assign hour_disp = {1'b0, hour_q};
  assign pm        = 1'b0;
`endif

  always_comb begin
    digit_en = 6'b111111;
    if (mode_q == SET_HH) digit_en[5:4] = {2{blink_q}};
    if (mode_q == SET_MM) digit_en[3:2] = {2{blink_q}};
  end

  assign mode     = mode_q;
  assign day_tick = day_tick_q;

  bin_to_bcd u_hh (.bin(hour_disp), .bcd(hh_bcd));
  bin_to_bcd u_mm (.bin(min_q),     .bcd(mm_bcd));
  bin_to_bcd u_ss (.bin(sec_q),     .bcd(ss_bcd));

endmodule

// File: doc/time_keeper.md
TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 Parameter RST_HH, default 0, hour loaded on reset (0..23).
REQ-002 Parameter RST_MM, default 0, minute loaded on reset (0..59).
REQ-003 clk  in  1  system clock, 100 MHz, single clock domain.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 pulse_1hz  in  1  one-cycle tick from the 1 Hz divider; each high cycle is one event.
REQ-006 btn_mode  in  1  one-cycle debounced mode pulse; each high cycle is one event.
REQ-007 btn_inc  in  1  one-cycle debounced increment pulse; each high cycle is one event.
REQ-008 hh_bcd  out  8  hours, two BCD digits, tens in [7:4].
REQ-009 mm_bcd  out  8  minutes, two BCD digits.
REQ-010 ss_bcd  out  8  seconds, two BCD digits.
REQ-011 digit_en  out  6  per-digit display enable, [5:4]=hh, [3:2]=mm, [1:0]=ss.
REQ-012 mode  out  2  current state encoding: RUN=0, SET_HH=1, SET_MM=2.
REQ-013 day_tick  out  1  one-cycle pulse on 23:59:59 -> 00:00:00 rollover.
REQ-014 pm  out  1  afternoon flag (see Configuration).

Function
REQ-015 Internal sec/min/hour held as binary registers; BCD outputs derived combinationally from those registers, visible the cycle after an update edge.
REQ-016 FSM states RUN, SET_HH, SET_MM; btn_mode moves RUN->SET_HH->SET_MM->RUN; no other transitions.
REQ-017 RUN: each pulse_1hz increments sec; sec 59->0 carries into min; min 59->0 carries into hour; hour 23->0 asserts day_tick for exactly that cycle.
REQ-018 SET_HH/SET_MM: pulse_1hz does not advance time; btn_inc increments the selected field only, hour 23->0, min 59->0, no carry, no day_tick.
REQ-019 SET_MM->RUN transition clears sec to 0 on the same edge.
REQ-020 btn_mode and btn_inc in the same cycle: mode transition taken, increment discarded.
REQ-021 btn_mode and pulse_1hz in the same cycle in RUN: the second is counted and the state moves to SET_HH on the same edge.
REQ-022 blink register toggles on every pulse_1hz while in SET states; forced to 1 in RUN.
REQ-023 digit_en all ones in RUN; in SET_HH, [5:4]=blink; in SET_MM, [3:2]=blink; other bits 1.
REQ-024 Inputs other than rst are used only at rising clk edges; no combinational input-to-output path except through registers.

Reset
REQ-025 rst asserted: state=RUN, hour=RST_HH, min=RST_MM, sec=0, blink=1, day_tick=0, immediately and without a clock edge.
REQ-026 rst asserted mid-SET discards the partial edit; operation resumes in RUN on the first edge after deassertion.

Configuration
REQ-027 Macro CLOCK_12H_EN defined: hh_bcd shows 12,01..11 for hours 0..11 and 12,01..11 for hours 12..23; pm=1 when hour>=12; internal counting stays 0..23.
REQ-028 CLOCK_12H_EN undefined: hh_bcd shows 00..23, pm tied 0.

Structure
REQ-029 Package clock_pkg holds the mode_t enum (RUN/SET_HH/SET_MM), SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23.
REQ-030 Sub-module bin_to_bcd (6-bit binary 0..59 in, 8-bit BCD out, combinational) is instantiated three times.

Verification
REQ-031 Reset with RST_HH=23, RST_MM=59; 59 pulses -> 23:59:59; one more -> 00:00:00, day_tick high for exactly 1 cycle.
REQ-032 btn_mode, 3x btn_inc -> SET_HH, hour=RST_HH+3; pulse_1hz in between leaves ss unchanged and toggles digit_en[5:4].
REQ-033 In SET_MM at min=59, btn_inc -> min=0, hour unchanged; btn_mode -> RUN, ss=00, digit_en=6'b111111.
REQ-034 btn_mode and btn_inc same cycle from RUN -> SET_HH, hour unchanged.
REQ-035 rst pulsed asynchronously mid-SET_MM -> outputs at reset values before next clk edge, mode=0.
REQ-036 With CLOCK_12H_EN, hour 0 -> hh_bcd=8'h12, pm=0; hour 13 -> hh_bcd=8'h01, pm=1.
